miner_slave_if: RTL and testbench

MINER_SLAVE_IF -- requirements
Module: miner_slave_if

---
 rtl/miner_slave_if.sv | 123 ++++++++++++
 tb/tb_miner_slave_if.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/miner_slave_if.sv
// Register slave for the mining core: shadow target/header, control/status FSM, found-nonce capture.
// Writes take effect on the edge; read data is registered (1 cycle); no backpressure, always ready.
module miner_slave_if #(
  parameter int TARGET_WORDS = 8,
  parameter int MSG_WORDS    = 19
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [4:0]                slaveAddr,
  input  logic [31:0]               slaveWriteData,
  input  logic                      slaveWrite,
  input  logic                      slaveRead,
  input  logic                      slaveChipSelect,
  output logic [31:0]               slaveReadData,
  output logic [TARGET_WORDS*32-1:0] target,
  output logic [MSG_WORDS*32-1:0]    header,
  output logic                      startMine,
  input  logic                      coreFound,
  input  logic [31:0]               coreNonce
);

  localparam int CTRL_ADDR  = 1;
  localparam int TGT_BASE   = 2;
  localparam int NONCE_ADDR = TGT_BASE + TARGET_WORDS;
  localparam int HDR_BASE   = NONCE_ADDR + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READY  = 2'd1,
    ST_MINING = 2'd2,
    ST_FOUND  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      tgt_valid;
  logic [31:0]               nonce_q;
  logic [TARGET_WORDS*32-1:0] shadow_tgt;
  logic [MSG_WORDS*32-1:0]    shadow_hdr;
  logic [31:0]               rd_word;

  logic wr_en, rd_en, ctrl_wr, tgt_load, start_go, found_hit;

  assign wr_en    = slaveChipSelect && slaveWrite;
  assign rd_en    = slaveChipSelect && slaveRead;
  assign ctrl_wr  = wr_en && (slaveAddr == 5'(CTRL_ADDR));
  assign tgt_load = ctrl_wr && slaveWriteData[0];
  // A start in the same write as a load is valid even before tgt_valid is set.
  assign start_go = ctrl_wr && slaveWriteData[1] && (tgt_valid || slaveWriteData[0]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    found_hit = 1'b0;
    if (start_go) begin
      state_d = ST_MINING;
    end else if (tgt_load && state_q == ST_IDLE) begin
      state_d = ST_READY;
    end else if (state_q == ST_MINING && coreFound) begin
      state_d   = ST_FOUND;
      found_hit = 1'b1;
    end
  end

  // Shadow register file, only touched by bus writes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow_tgt <= '0;
      shadow_hdr <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < TARGET_WORDS; i++) begin
        if (slaveAddr == 5'(TGT_BASE + i)) shadow_tgt[i*32 +: 32] <= slaveWriteData;
      end
      for (int i = 0; i < MSG_WORDS; i++) begin
        if (slaveAddr == 5'(HDR_BASE + i)) shadow_hdr[i*32 +: 32] <= slaveWriteData;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      target    <= '0;
      header    <= '0;
      tgt_valid <= 1'b0;
      nonce_q   <= '0;
      startMine <= 1'b0;
    end else begin
      startMine <= start_go;
      if (tgt_load) begin
        target    <= shadow_tgt;
        tgt_valid <= 1'b1;
      end
      if (start_go) begin
        header  <= shadow_hdr;
        nonce_q <= '0;
      end else if (found_hit) begin
        nonce_q <= coreNonce;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (slaveAddr == 5'd0)              rd_word = {30'b0, state_q};
    if (slaveAddr == 5'(NONCE_ADDR))    rd_word = nonce_q;
    for (int i = 0; i < TARGET_WORDS; i++) begin
      if (slaveAddr == 5'(TGT_BASE + i)) rd_word = shadow_tgt[i*32 +: 32];
    end
    for (int i = 0; i < MSG_WORDS; i++) begin
      if (slaveAddr == 5'(HDR_BASE + i)) rd_word = shadow_hdr[i*32 +: 32];
    end
  end

  // Read data holds its last value between reads; a same-edge write is not yet visible.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     slaveReadData <= '0;
    else if (rd_en) slaveReadData <= rd_word;
  end

endmodule

// File: tb/tb_miner_slave_if.sv
// Bench for miner_slave_if: register-map model compared every cycle plus directed literal checks.
module tb_miner_slave_if;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [4:0]   slaveAddr = '0;
  logic [31:0]  slaveWriteData = '0;
  logic         slaveWrite = 1'b0;
  logic         slaveRead = 1'b0;
  logic         slaveChipSelect = 1'b0;
  logic [31:0]  slaveReadData;
  logic [255:0] target;
  logic [607:0] header;
  logic         startMine;
  logic         coreFound = 1'b0;
  logic [31:0]  coreNonce = '0;

  miner_slave_if dut (
    .clk(clk), .n_rst(n_rst), .slaveAddr(slaveAddr), .slaveWriteData(slaveWriteData),
    .slaveWrite(slaveWrite), .slaveRead(slaveRead), .slaveChipSelect(slaveChipSelect),
    .slaveReadData(slaveReadData), .target(target), .header(header),
    .startMine(startMine), .coreFound(coreFound), .coreNonce(coreNonce)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [607:0] act, input logic [607:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model of the register map.
  logic [31:0]  m_tsh [8];
  logic [31:0]  m_hsh [19];
  logic [255:0] m_target;
  logic [607:0] m_header;
  int           m_status;
  bit           m_tv;
  logic [31:0]  m_nonce;
  bit           m_pulse;
  logic [31:0]  m_rdata;
  int           m_st0;
  bit           m_ld, m_go;

  function automatic logic [31:0] model_read(input int a);
    if (a == 0)             return 32'(m_status);
    if (a >= 2 && a <= 9)   return m_tsh[a-2];
    if (a == 10)            return m_nonce;
    if (a >= 11 && a <= 29) return m_hsh[a-11];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 8; i++)  m_tsh[i] = '0;
      for (int i = 0; i < 19; i++) m_hsh[i] = '0;
      m_target = '0; m_header = '0; m_status = 0; m_tv = 0;
      m_nonce = '0; m_pulse = 0; m_rdata = '0;
    end else begin
      m_st0 = m_status;
      m_pulse = 0; m_ld = 0; m_go = 0;
      if (slaveChipSelect && slaveRead) m_rdata = model_read(int'(slaveAddr));
      if (slaveChipSelect && slaveWrite) begin
        if (slaveAddr >= 2 && slaveAddr <= 9)   m_tsh[slaveAddr-2]  = slaveWriteData;
        if (slaveAddr >= 11 && slaveAddr <= 29) m_hsh[slaveAddr-11] = slaveWriteData;
        if (slaveAddr == 1) begin
          m_ld = slaveWriteData[0];
          m_go = slaveWriteData[1] && (m_tv || m_ld);
        end
      end
      if (m_ld) begin
        for (int i = 0; i < 8; i++) m_target[i*32 +: 32] = m_tsh[i];
        m_tv = 1;
        if (m_status == 0) m_status = 1;
      end
      if (m_go) begin
        for (int i = 0; i < 19; i++) m_header[i*32 +: 32] = m_hsh[i];
        m_nonce = '0; m_status = 2; m_pulse = 1;
      end else if (m_st0 == 2 && coreFound) begin
        m_status = 3; m_nonce = coreNonce;
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      check("cyc_target", 608'(target), 608'(m_target));
      check("cyc_header", header, m_header);
      check("cyc_startMine", 608'(startMine), 608'(m_pulse));
      check("cyc_rdata", 608'(slaveReadData), 608'(m_rdata));
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    slaveChipSelect = 1; slaveWrite = 1; slaveAddr = a; slaveWriteData = d;
    @(negedge clk);
    slaveChipSelect = 0; slaveWrite = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    slaveChipSelect = 1; slaveRead = 1; slaveAddr = a;
    @(negedge clk);
    v = slaveReadData;
    slaveChipSelect = 0; slaveRead = 0;
  endtask

  logic [31:0] v;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_target", 608'(target), 608'h0);
    check("rst_rdata", 608'(slaveReadData), 608'h0);
    n_rst = 1;
    @(negedge clk);

    // start with no target loaded
    wr(5'd1, 32'd2);
    check("nostart_pulse", 608'(startMine), 608'h0);
    rd(5'd0, v); check("nostart_status", 608'(v), 608'h0);

    // target load
    wr(5'd9, 32'h1000_0000);
    for (int a = 8; a >= 2; a--) wr(5'(a), 32'h0);
    wr(5'd1, 32'd1);
    check("load_target", 608'(target), 608'({32'h1000_0000, 224'h0}));
    check("load_pulse", 608'(startMine), 608'h0);
    rd(5'd0, v); check("load_status", 608'(v), 608'h1);

    // header + start
    for (int a = 29; a >= 11; a--) wr(5'(a), 32'hA000_0000 + 32'(a - 11));
    wr(5'd1, 32'd2);
    check("start_pulse", 608'(startMine), 608'h1);
    @(negedge clk);
    check("start_pulse_once", 608'(startMine), 608'h0);
    check("start_hdr_lo", 608'(header[31:0]), 608'hA000_0000);
    check("start_hdr_hi", 608'(header[607:576]), 608'hA000_0012);
    rd(5'd0, v);  check("start_status", 608'(v), 608'h2);
    rd(5'd10, v); check("start_nonce", 608'(v), 608'h0);

    // found
    coreFound = 1; coreNonce = 32'd42;
    @(negedge clk);
    coreFound = 0; coreNonce = 32'd99;
    rd(5'd0, v);  check("found_status", 608'(v), 608'h3);
    rd(5'd10, v); check("found_nonce", 608'(v), 608'd42);

    // coreFound outside MINING is ignored
    coreFound = 1; coreNonce = 32'd77;
    @(negedge clk);
    coreFound = 0;
    rd(5'd10, v); check("found_ignored", 608'(v), 608'd42);

    // restart from FOUND with unchanged header
    wr(5'd1, 32'd2);
    check("restart_pulse", 608'(startMine), 608'h1);
    rd(5'd10, v); check("restart_nonce", 608'(v), 608'h0);
    rd(5'd0, v);  check("restart_status", 608'(v), 608'h2);
    check("restart_hdr", 608'(header[31:0]), 608'hA000_0000);

    // shadow write while mining, then reset mid-search
    wr(5'd11, 32'hDEAD_BEEF);
    check("shadow_hdr_hold", 608'(header[31:0]), 608'hA000_0000);
    rd(5'd11, v); check("shadow_read", 608'(v), 608'hDEAD_BEEF);
    #2 n_rst = 0;
    #1;
    check("arst_target", 608'(target), 608'h0);
    check("arst_header", header, 608'h0);
    check("arst_pulse", 608'(startMine), 608'h0);
    check("arst_rdata", 608'(slaveReadData), 608'h0);
    @(negedge clk);
    n_rst = 1;
    repeat (3) @(negedge clk);
    rd(5'd0, v); check("post_rst_status", 608'(v), 608'h0);

    // load + start in one write
    wr(5'd9, 32'd5);
    wr(5'd1, 32'd3);
    check("both_pulse", 608'(startMine), 608'h1);
    check("both_target", 608'(target[255:224]), 608'd5);

    // start and coreFound on the same edge: start wins
    slaveChipSelect = 1; slaveWrite = 1; slaveAddr = 5'd1; slaveWriteData = 32'd2;
    coreFound = 1; coreNonce = 32'd7;
    @(negedge clk);
    slaveChipSelect = 0; slaveWrite = 0; coreFound = 0;
    check("race_pulse", 608'(startMine), 608'h1);
    rd(5'd10, v); check("race_nonce", 608'(v), 608'h0);
    rd(5'd0, v);  check("race_status", 608'(v), 608'h2);

    // target reload during MINING, then no-op control
    wr(5'd8, 32'd1);
    wr(5'd1, 32'd1);
    check("reload_pulse", 608'(startMine), 608'h0);
    check("reload_target", 608'(target[223:192]), 608'd1);
    wr(5'd1, 32'd0);
    check("noop_pulse", 608'(startMine), 608'h0);
    rd(5'd0, v); check("reload_status", 608'(v), 608'h2);

    // ignored addresses
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd10, 32'h55);
    wr(5'd30, 32'h66);
    wr(5'd31, 32'h77);
    rd(5'd10, v); check("ign_nonce", 608'(v), 608'h0);
    rd(5'd0, v);  check("ign_status", 608'(v), 608'h2);
    rd(5'd30, v); check("ign_a30", 608'(v), 608'h0);

    // simultaneous read and write returns the old value
    slaveChipSelect = 1; slaveRead = 1; slaveWrite = 1; slaveAddr = 5'd12;
    slaveWriteData = 32'h1234_5678;
    @(negedge clk);
    slaveChipSelect = 0; slaveRead = 0; slaveWrite = 0;
    check("rw_old", 608'(slaveReadData), 608'h0);
    rd(5'd12, v); check("rw_new", 608'(v), 608'h1234_5678);

    // held read data with no read
    repeat (2) @(negedge clk);
    check("rd_hold", 608'(slaveReadData), 608'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
